rf16b_clk_en: RTL and testbench

RF16B_CLK_EN -- requirements
Module: rf16b_clk_en

---
 rtl/rf16b_clk_en.sv | 48 ++++
 tb/tb_rf16b_clk_en.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rf16b_clk_en.sv
// rf16b_clk_en: WIDTH-bit register clocked on the falling edge of clk_n, with a clock enable.
//
// Ports:
//   clk_n  - sole clock, active-low; state updates on its falling edge
//   rst    - asynchronous active-high reset; forces Q to zero immediately
//   clk_en - active-high load enable, sampled on falling edges of clk_n
//   D      - WIDTH-bit data to be stored
//   Q      - WIDTH-bit stored contents, driven straight from the flops
//
// The enable is a per-bit hold/load mux in front of each flop, so the clock is never gated.
// Each bit has its own mux and flop, which keeps the bits fully independent of one another.
// Q comes straight from the flops, so there is no combinational path from D or clk_en to Q.

module rf16b_clk_en #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] reg_d;
  logic [WIDTH-1:0] reg_q;

  // Per-bit select: pass D when enabled, otherwise recirculate the stored bit.
  // When clk_en is high, the next state depends only on D. An earlier unknown value in reg_q
  // therefore cannot carry past a loading edge.
  always_comb begin
    reg_d = reg_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      reg_d[i] = clk_en ? D[i] : reg_q[i];
    end
  end

  // Falling-edge state with an asynchronous clear. Reset takes priority over any load.
  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign Q = reg_q;

endmodule

// File: tb/tb_rf16b_clk_en.sv
// tb_rf16b_clk_en: self-checking bench for rf16b_clk_en.
// It applies a vector table, then hand-written sequences for the edge-sensitivity and
// asynchronous-reset cases.

module tb_rf16b_clk_en;

  localparam int unsigned WIDTH = 16;

  logic             clk_n;
  logic             rst;
  logic             clk_en;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp;
    string            name;
  } vec_t;

  vec_t vecs[$];

  rf16b_clk_en #(
    .WIDTH(WIDTH)
  ) dut (
    .clk_n (clk_n),
    .rst   (rst),
    .clk_en(clk_en),
    .D     (D),
    .Q     (Q)
  );

  // 20 ns period, starting high: falling edges at 10, 30, ... and rising edges at 20, 40, ...
  initial begin
    clk_n = 1'b1;
    forever #10 clk_n = ~clk_n;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: Q=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the rising edge and queue the expectation.
  // Pop that expectation and compare it just after the following falling edge.
  task automatic drive_cycle(input logic r, input logic en, input logic [WIDTH-1:0] d,
                             input logic [WIDTH-1:0] exp, input string name);
    logic [WIDTH-1:0] e;
    @(posedge clk_n);
    rst    = r;
    clk_en = en;
    D      = d;
    exp_q.push_back(exp);
    @(negedge clk_n);
    #2;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, actual=0 entries required=1", name);
    end else begin
      e = exp_q.pop_front();
      check(name, Q, e);
    end
  endtask

  initial begin
    // Reset asserted from time zero while clk_en and D try to load all ones.
    rst    = 1'b1;
    clk_en = 1'b1;
    D      = 16'hFFFF;
    #1;
    check("reset_immediate", Q, 16'h0000);

    vecs.push_back('{1'b1, 1'b1, 16'hFFFF, 16'h0000, "reset_edge_0"});
    vecs.push_back('{1'b1, 1'b1, 16'hFFFF, 16'h0000, "reset_edge_1"});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, "en_low_0"});
    vecs.push_back('{1'b0, 1'b0, 16'h1111, 16'h0000, "en_low_1"});
    vecs.push_back('{1'b0, 1'b0, 16'h1111, 16'h0000, "en_low_2"});
    vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0000, "load_0000"});
    vecs.push_back('{1'b0, 1'b1, 16'h1111, 16'h1111, "load_1111"});
    vecs.push_back('{1'b0, 1'b1, 16'h2222, 16'h2222, "load_2222"});
    vecs.push_back('{1'b0, 1'b1, 16'h4444, 16'h4444, "load_4444"});
    vecs.push_back('{1'b0, 1'b1, 16'h8888, 16'h8888, "load_8888"});
    vecs.push_back('{1'b0, 1'b1, 16'hCCCC, 16'hCCCC, "load_cccc"});
    vecs.push_back('{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "load_ffff"});
    vecs.push_back('{1'b0, 1'b1, 16'hCCCC, 16'hCCCC, "load_cccc_again"});
    vecs.push_back('{1'b0, 1'b0, 16'h1234, 16'hCCCC, "hold_cccc_0"});
    vecs.push_back('{1'b0, 1'b0, 16'h1234, 16'hCCCC, "hold_cccc_1"});
    vecs.push_back('{1'b0, 1'b1, 16'h1234, 16'h1234, "load_1234"});

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].exp, vecs[i].name);
    end

    // Walking one: each bit loads independently of its neighbours.
    for (int i = 0; i < int'(WIDTH); i++) begin
      logic [WIDTH-1:0] w;
      w = '0;
      w[i] = 1'b1;
      drive_cycle(1'b0, 1'b1, w, w, $sformatf("walk_%0d", i));
    end

    // D changes while clk_n is low; the rising edge must not capture it.
    drive_cycle(1'b0, 1'b1, 16'h5A5A, 16'h5A5A, "load_5a5a");
    #3;
    D = 16'hA5A5;
    @(posedge clk_n);
    #1;
    check("rise_ignored", Q, 16'h5A5A);
    clk_en = 1'b0;
    @(negedge clk_n);
    #2;
    check("hold_after_midlow_change", Q, 16'h5A5A);

    // Asynchronous reset pulsed between edges while Q is all ones.
    drive_cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "load_ffff_pre_reset");
    #4;
    rst = 1'b1;
    #1;
    check("async_reset_mid", Q, 16'h0000);
    @(negedge clk_n);
    #2;
    check("reset_blocks_load", Q, 16'h0000);
    drive_cycle(1'b0, 1'b0, 16'h7777, 16'h0000, "post_reset_hold_zero");
    drive_cycle(1'b0, 1'b1, 16'h7777, 16'h7777, "post_reset_first_load");

    // Short reset pulse that stays between edges.
    #3;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("reset_pulse_clears", Q, 16'h0000);
    clk_en = 1'b0;
    @(negedge clk_n);
    #2;
    check("reset_pulse_hold", Q, 16'h0000);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: entries=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
